// File: rtl/nco_tune_ctrl.sv
// NCO tuning controller: moves the phase-increment word to a requested target
// either in one jump or as a ramp of fixed steps separated by a dwell time.
module nco_tune_ctrl #(
    parameter int REGISTER_WIDTH = 64,
    parameter int DWELL_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [REGISTER_WIDTH-1:0] req_target,
    input  logic [REGISTER_WIDTH-1:0] req_step,
    input  logic [DWELL_WIDTH-1:0]    req_dwell,
    input  logic                      abort,
    output logic [REGISTER_WIDTH-1:0] phase_increment,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [REGISTER_WIDTH-1:0] phase_q, phase_d;
    logic [REGISTER_WIDTH-1:0] target_q, target_d;
    logic [REGISTER_WIDTH-1:0] step_q, step_d;
    logic [DWELL_WIDTH-1:0]    dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0]    cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      going_up;
    logic [REGISTER_WIDTH-1:0] distance;

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign phase_increment = phase_q;

    // Distance is taken in the direction of travel so a step never overshoots or wraps.
    always_comb begin
        going_up = (target_q >= phase_q);
        distance = going_up ? (target_q - phase_q) : (phase_q - target_q);
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        target_d = target_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    step_d   = req_step;
                    dwell_d  = req_dwell;
                    if (req_target == phase_q) begin
                        state_d = SETTLE;
                    end else if (req_step == '0) begin
                        phase_d = req_target;
                        state_d = SETTLE;
                    end else begin
                        cnt_d   = req_dwell;
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end else begin
                    cnt_d = dwell_q;
                    if (distance <= step_q) begin
                        phase_d = target_q;
                        state_d = SETTLE;
                    end else if (going_up) begin
                        phase_d = phase_q + step_q;
                    end else begin
                        phase_d = phase_q - step_q;
                    end
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == SETTLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            target_q <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Directed self-checking bench for nco_tune_ctrl; outputs are sampled on the
// falling clock edge and inputs are changed there too.
module tb_nco_tune_ctrl;

    localparam int RW = 64;
    localparam int DW = 16;
    localparam logic [RW-1:0] ALL_ONES = {RW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [RW-1:0] req_target = '0;
    logic [RW-1:0] req_step = '0;
    logic [DW-1:0] req_dwell = '0;
    logic          abort = 1'b0;
    logic [RW-1:0] phase_increment;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    nco_tune_ctrl #(.REGISTER_WIDTH(RW), .DWELL_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_target(req_target), .req_step(req_step), .req_dwell(req_dwell),
        .abort(abort), .phase_increment(phase_increment), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic request(input logic [RW-1:0] t, input logic [RW-1:0] s, input logic [DW-1:0] d);
        req_valid  = 1'b1;
        req_target = t;
        req_step   = s;
        req_dwell  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (phase_increment !== '0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: phase=%h busy=%b ready=%b done=%b, want phase=0 busy=0 ready=1 done=0",
                     phase_increment, busy, req_ready, done);
        end
    endtask

    // Leaves reset and presents the request in the same cycle, so it is taken on the first edge.
    task automatic test_up_ramp();
        logic [RW-1:0] ep [0:5] = '{0, 3, 6, 9, 10, 10};
        logic          ed [0:5] = '{0, 0, 0, 0, 1, 0};
        logic          eb [0:5] = '{1, 1, 1, 1, 1, 0};
        rst_n = 1'b1;
        request(10, 3, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = 1'b0;
            checks++;
            if (phase_increment !== ep[i] || done !== ed[i] || busy !== eb[i] || req_ready !== !eb[i]) begin
                failures++;
                $display("[TB] FAIL up_ramp[%0d]: phase=%0d done=%b busy=%b ready=%b, want phase=%0d done=%b busy=%b",
                         i, phase_increment, done, busy, req_ready, ep[i], ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_down_ramp_dwell();
        logic [RW-1:0] ep [0:10] = '{10, 10, 10, 8, 8, 8, 6, 6, 6, 4, 4};
        logic          ed [0:10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic          eb [0:10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        request(4, 2, 2);
        for (int i = 0; i < 11; i++) begin
            tick();
            req_valid = 1'b0;
            checks++;
            if (phase_increment !== ep[i] || done !== ed[i] || busy !== eb[i]) begin
                failures++;
                $display("[TB] FAIL down_ramp[%0d]: phase=%0d done=%b busy=%b, want phase=%0d done=%b busy=%b",
                         i, phase_increment, done, busy, ep[i], ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_jump(input logic [RW-1:0] t);
        request(t, 0, 0);
        tick();
        req_valid = 1'b0;
        checks++;
        if (phase_increment !== t || done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jump_settle: phase=%h done=%b busy=%b, want phase=%h done=1 busy=1",
                     phase_increment, done, busy, t);
        end
        tick();
        checks++;
        if (phase_increment !== t || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_idle: phase=%h done=%b busy=%b, want phase=%h done=0 busy=0",
                     phase_increment, done, busy, t);
        end
    endtask

    task automatic test_equal_target();
        request(ALL_ONES, 5, 3);
        tick();
        req_valid = 1'b0;
        checks++;
        if (phase_increment !== ALL_ONES || done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL equal_target: phase=%h done=%b busy=%b, want phase=%h done=1 busy=1",
                     phase_increment, done, busy, ALL_ONES);
        end
        tick();
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL equal_target_idle: done=%b ready=%b, want done=0 ready=1", done, req_ready);
        end
    endtask

    task automatic test_no_wrap();
        logic [RW-1:0] half = {1'b1, {(RW-1){1'b0}}};
        logic [RW-1:0] ep [0:3];
        logic          ed [0:3] = '{0, 0, 1, 0};
        ep = '{0, half, ALL_ONES, ALL_ONES};
        request(ALL_ONES, half, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            req_valid = 1'b0;
            checks++;
            if (phase_increment !== ep[i] || done !== ed[i]) begin
                failures++;
                $display("[TB] FAIL no_wrap[%0d]: phase=%h done=%b, want phase=%h done=%b",
                         i, phase_increment, done, ep[i], ed[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [RW-1:0] ep [0:3] = '{0, 10, 20, 30};
        int            done_seen = 0;
        request(100, 10, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            req_valid = 1'b0;
            if (done === 1'b1) done_seen++;
            checks++;
            if (phase_increment !== ep[i] || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL abort_ramp[%0d]: phase=%0d busy=%b, want phase=%0d busy=1",
                         i, phase_increment, busy, ep[i]);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (done === 1'b1) done_seen++;
        checks++;
        if (phase_increment !== 30 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_hold: phase=%0d busy=%b, want phase=30 busy=0", phase_increment, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || phase_increment !== 30) begin
            failures++;
            $display("[TB] FAIL abort_no_done: done pulses=%0d phase=%0d, want 0 pulses phase=30",
                     done_seen, phase_increment);
        end
    endtask

    // Abort is meaningless outside a ramp: a request taken with abort high still completes.
    task automatic test_abort_ignored_idle();
        abort = 1'b1;
        request(7, 0, 0);
        tick();
        req_valid = 1'b0;
        checks++;
        if (phase_increment !== 7 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_idle: phase=%0d done=%b, want phase=7 done=1", phase_increment, done);
        end
        tick();
        abort = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || phase_increment !== 7) begin
            failures++;
            $display("[TB] FAIL abort_settle: ready=%b phase=%0d, want ready=1 phase=7", req_ready, phase_increment);
        end
    endtask

    task automatic test_reset_mid_ramp();
        request(1000, 1, 0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (phase_increment !== 9 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset: phase=%0d busy=%b, want phase=9 busy=1", phase_increment, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (phase_increment !== '0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: phase=%0d busy=%b ready=%b done=%b, want 0 0 1 0",
                     phase_increment, busy, req_ready, done);
        end
        tick();
    endtask

    // req_valid stays high throughout; the bench only changes the payload.
    task automatic test_back_to_back();
        logic [RW-1:0] ep [0:6] = '{5, 5, 5, 8, 8, 3, 3};
        logic          ed [0:6] = '{1, 0, 0, 1, 0, 1, 0};
        logic          ey [0:6] = '{0, 1, 0, 0, 1, 0, 1};
        rst_n = 1'b1;
        request(5, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) request(8, 3, 0);
            if (i == 3) request(3, 0, 0);
            if (i == 5) req_valid = 1'b0;
            checks++;
            if (phase_increment !== ep[i] || done !== ed[i] || req_ready !== ey[i]) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d]: phase=%0d done=%b ready=%b, want phase=%0d done=%b ready=%b",
                         i, phase_increment, done, req_ready, ep[i], ed[i], ey[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_ramp_dwell();
        test_jump(ALL_ONES);
        test_equal_target();
        test_jump('0);
        test_no_wrap();
        test_jump('0);
        test_abort();
        test_abort_ignored_idle();
        test_reset_mid_ramp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
